// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main control FSM: FETCH, DECODE, EXEC, MEM, WB plus traps.
// Define CTRL_PERF_EN to add the cycle_cnt / instret_cnt performance counters.

`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef IMM_OP_WIDTH
`define IMM_OP_WIDTH 3
`endif
`ifndef IMM_OP_I
`define IMM_OP_I 3'd0
`endif
`ifndef IMM_OP_S
`define IMM_OP_S 3'd1
`endif
`ifndef IMM_OP_B
`define IMM_OP_B 3'd2
`endif
`ifndef IMM_OP_U
`define IMM_OP_U 3'd3
`endif
`ifndef IMM_OP_J
`define IMM_OP_J 3'd4
`endif

module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [`CPU_WIDTH-1:0]    ir,
    input  logic                     br_taken,
    input  logic                     imem_ready,
    input  logic                     dmem_ready,
    output logic                     imem_req,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic                     ir_we,
    output logic [`IMM_OP_WIDTH-1:0] imm_op,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic                     rf_we,
    output logic [1:0]               wb_sel,
    output logic                     halted,
    output logic                     illegal_instr,
    output logic                     bus_err
`ifdef CTRL_PERF_EN
    ,
    output logic [31:0]              cycle_cnt,
    output logic [31:0]              instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC,
        S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_LOAD, C_STORE,
        C_BRANCH, C_JAL, C_JALR
    } cls_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam bit TO_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        TO_EN ? CNT_W'(MEM_TIMEOUT - 1) : '0;

    state_t                   state;
    state_t                   state_nxt;
    cls_t                     cls;
    cls_t                     cls_nxt;
    cls_t                     dec_cls;
    logic [`IMM_OP_WIDTH-1:0] dec_imm;
    logic [`IMM_OP_WIDTH-1:0] imm_nxt;
    logic                     dec_sys;
    logic                     dec_ill;
    logic [6:0]               opc;
    logic [CNT_W-1:0]         to_cnt;
    logic                     waiting;
    logic                     timeout_hit;
    logic                     br_exec;
    logic [1:0]               pc_src_q;
    logic [1:0]               pc_src_nxt;
    logic [1:0]               wb_sel_nxt;
    logic                     unused_ir;

    assign opc       = ir[6:0];
    assign unused_ir = ^ir[`CPU_WIDTH-1:7];

    always_comb begin
        dec_cls = C_NONE;
        dec_imm = imm_op;
        dec_sys = 1'b0;
        dec_ill = 1'b0;
        unique case (1'b1)
            (opc == OP_R): dec_cls = C_ALU;
            (opc == OP_ALUI): begin
                dec_cls = C_ALU;
                dec_imm = `IMM_OP_I;
            end
            (opc == OP_LOAD): begin
                dec_cls = C_LOAD;
                dec_imm = `IMM_OP_I;
            end
            (opc == OP_JALR): begin
                dec_cls = C_JALR;
                dec_imm = `IMM_OP_I;
            end
            (opc == OP_STORE): begin
                dec_cls = C_STORE;
                dec_imm = `IMM_OP_S;
            end
            (opc == OP_BRANCH): begin
                dec_cls = C_BRANCH;
                dec_imm = `IMM_OP_B;
            end
            (opc == OP_LUI),
            (opc == OP_AUIPC): begin
                dec_cls = C_ALU;
                dec_imm = `IMM_OP_U;
            end
            (opc == OP_JAL): begin
                dec_cls = C_JAL;
                dec_imm = `IMM_OP_J;
            end
            (opc == OP_SYS): dec_sys = 1'b1;
            default: dec_ill = 1'b1;
        endcase
    end

    // Ready that matters depends on which memory is being waited on
    assign waiting = (state == S_FETCH && !imem_ready) ||
                     (state == S_MEM && !dmem_ready);
    assign timeout_hit = TO_EN && waiting && (to_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        imm_nxt   = imm_op;
        unique case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                if (imem_ready)
                    state_nxt = S_DECODE;
                else if (timeout_hit)
                    state_nxt = S_TRAP;
            end
            S_DECODE: begin
                if (dec_sys) begin
                    state_nxt = S_HALT;
                end else if (dec_ill) begin
                    state_nxt = S_TRAP;
                end else begin
                    state_nxt = S_EXEC;
                    cls_nxt   = dec_cls;
                    imm_nxt   = dec_imm;
                end
            end
            S_EXEC: begin
                unique case (cls)
                    C_LOAD, C_STORE: state_nxt = S_MEM;
                    C_BRANCH: state_nxt = S_FETCH;
                    default: state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ready)
                    state_nxt = (cls == C_LOAD) ? S_WB : S_FETCH;
                else if (timeout_hit)
                    state_nxt = S_TRAP;
            end
            S_WB: state_nxt = S_FETCH;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        pc_src_nxt = 2'd0;
        wb_sel_nxt = 2'd0;
        if (state_nxt == S_WB) begin
            unique case (cls_nxt)
                C_JAL: begin
                    pc_src_nxt = 2'd1;
                    wb_sel_nxt = 2'd2;
                end
                C_JALR: begin
                    pc_src_nxt = 2'd2;
                    wb_sel_nxt = 2'd2;
                end
                C_LOAD: wb_sel_nxt = 2'd1;
                default: wb_sel_nxt = 2'd0;
            endcase
        end
    end

    // Moore outputs are registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cls           <= C_NONE;
            imm_op        <= `IMM_OP_I;
            to_cnt        <= '0;
            imem_req      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            br_exec       <= 1'b0;
            rf_we         <= 1'b0;
            wb_sel        <= 2'd0;
            pc_src_q      <= 2'd0;
            halted        <= 1'b0;
            illegal_instr <= 1'b0;
            bus_err       <= 1'b0;
        end else begin
            state    <= state_nxt;
            cls      <= cls_nxt;
            imm_op   <= imm_nxt;
            imem_req <= (state_nxt == S_FETCH);
            dmem_req <= (state_nxt == S_MEM);
            dmem_we  <= (state_nxt == S_MEM) && (cls_nxt == C_STORE);
            br_exec  <= (state_nxt == S_EXEC) && (cls_nxt == C_BRANCH);
            rf_we    <= (state_nxt == S_WB);
            wb_sel   <= wb_sel_nxt;
            pc_src_q <= pc_src_nxt;
            if (state_nxt == S_HALT)
                halted <= 1'b1;
            if (state == S_DECODE && state_nxt == S_TRAP)
                illegal_instr <= 1'b1;
            if (timeout_hit)
                bus_err <= 1'b1;
            if (state_nxt != state)
                to_cnt <= '0;
            else if (TO_EN && waiting)
                to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign ir_we  = imem_req & imem_ready;
    assign pc_we  = rf_we | br_exec |
                    (dmem_req & dmem_we & dmem_ready);
    assign pc_src = br_exec ? {1'b0, br_taken} : pc_src_q;

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= 32'd0;
            instret_cnt <= 32'd0;
        end else begin
            if (state != S_IDLE && state != S_HALT && state != S_TRAP)
                cycle_cnt <= cycle_cnt + 32'd1;
            if (pc_we)
                instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction table plus
// hand-written wait-state, trap, timeout and reset sequences.

`ifndef IMM_OP_I
`define IMM_OP_I 3'd0
`endif
`ifndef IMM_OP_S
`define IMM_OP_S 3'd1
`endif
`ifndef IMM_OP_B
`define IMM_OP_B 3'd2
`endif
`ifndef IMM_OP_U
`define IMM_OP_U 3'd3
`endif
`ifndef IMM_OP_J
`define IMM_OP_J 3'd4
`endif

module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int IMM_I = int'(`IMM_OP_I);
    localparam int IMM_S = int'(`IMM_OP_S);
    localparam int IMM_B = int'(`IMM_OP_B);
    localparam int IMM_U = int'(`IMM_OP_U);
    localparam int IMM_J = int'(`IMM_OP_J);

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] SW   = 32'h0020A223;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] ir = 32'd0;
    logic        br_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we;
    logic [2:0]  imm_op;
    logic        pc_we, rf_we;
    logic [1:0]  pc_src, wb_sel;
    logic        halted, illegal_instr, bus_err;
`ifdef CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ir(ir),
        .br_taken(br_taken),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req(imem_req),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .ir_we(ir_we),
        .imm_op(imm_op),
        .pc_we(pc_we),
        .pc_src(pc_src),
        .rf_we(rf_we),
        .wb_sel(wb_sel),
        .halted(halted),
        .illegal_instr(illegal_instr),
        .bus_err(bus_err)
`ifdef CTRL_PERF_EN
        ,
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        int lat;
        int ireq_n;
        int ir_we_n;
        int pc_we_n;
        int rf_we_n;
        int pc_src_v;
        int wb_sel_v;
        int dreq_n;
        int dwe_n;
        int bad;
        int pc_on_drdy;
        int ir_to_rf;
        int term;
    } stat_t;

    typedef struct packed {
        logic [31:0] instr;
        int br;
        int imm;
        int lat;
        int pc_n;
        int rf_n;
        int psrc;
        int wsel;
        int dreq;
        int dwe;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the DUT in FETCH; runs one
    // instruction until the next FETCH or a terminal flag.
    task automatic run_gen(input logic [31:0] instr, input logic br,
                           input int iwait, input int dwait,
                           output stat_t s);
        int  c, icnt, dcnt, ir_at;
        bit  left, done;
        s = '0;
        s.ir_to_rf = -1;
        ir = instr;
        br_taken = br;
        c = 0; icnt = 0; dcnt = 0; ir_at = -1;
        left = 0; done = 0;
        while (!done) begin
            imem_ready = imem_req && (icnt == iwait);
            dmem_ready = dmem_req && (dcnt == dwait);
            #1;
            if (halted || illegal_instr || bus_err || c > 40) begin
                s.term = 1;
                done = 1;
            end else if (imem_req && left) begin
                done = 1;
            end else begin
                if (!imem_req) left = 1;
                if (imem_req) begin s.ireq_n++; icnt++; end
                if (dmem_req) begin s.dreq_n++; dcnt++; end
                if (dmem_we) s.dwe_n++;
                if (ir_we) begin s.ir_we_n++; ir_at = c; end
                if (pc_we) begin
                    s.pc_we_n++;
                    s.pc_src_v = int'(pc_src);
                    if (dmem_ready) s.pc_on_drdy++;
                end else if (pc_src != 2'd0) s.bad++;
                if (rf_we) begin
                    s.rf_we_n++;
                    s.wb_sel_v = int'(wb_sel);
                    s.ir_to_rf = c - ir_at;
                    if (!pc_we) s.bad++;
                end else if (wb_sel != 2'd0) s.bad++;
                c++;
                @(negedge clk);
            end
        end
        s.lat = c;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t  vecs[10];
        stat_t s;
        int    n;
        logic  [2:0] pulses;

        vecs[0] = '{ADDI,         0, IMM_I, 4, 1, 1, 0, 0, 0, 0};
        vecs[1] = '{32'h00000463, 1, IMM_B, 3, 1, 0, 1, 0, 0, 0};
        vecs[2] = '{32'h00000463, 0, IMM_B, 3, 1, 0, 0, 0, 0, 0};
        vecs[3] = '{32'h008000EF, 0, IMM_J, 4, 1, 1, 1, 2, 0, 0};
        vecs[4] = '{32'h002081B3, 0, IMM_J, 4, 1, 1, 0, 0, 0, 0};
        vecs[5] = '{32'h123452B7, 0, IMM_U, 4, 1, 1, 0, 0, 0, 0};
        vecs[6] = '{LW,           0, IMM_I, 5, 1, 1, 0, 1, 1, 0};
        vecs[7] = '{SW,           0, IMM_S, 4, 1, 0, 0, 0, 1, 1};
        vecs[8] = '{32'h000080E7, 0, IMM_I, 4, 1, 1, 2, 2, 0, 0};
        vecs[9] = '{32'h00001197, 0, IMM_U, 4, 1, 1, 0, 0, 0, 0};

        #2 rst_n = 1'b0;
        imem_ready = 1'b1;
        #1;
        chk("reset_outs", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we,
                               pc_src, rf_we, wb_sel, halted,
                               illegal_instr, bus_err}), 32'd0);
        chk("reset_imm", 32'(imm_op), 32'(IMM_I));
        do_reset();
        chk("fetch_after_reset", 32'(imem_req), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_gen(vecs[i].instr, vecs[i].br[0], 0, 0, s);
            chk($sformatf("v%0d_lat", i), s.lat, vecs[i].lat);
            chk($sformatf("v%0d_imm", i), 32'(imm_op), vecs[i].imm);
            chk($sformatf("v%0d_ir_we", i), s.ir_we_n, 1);
            chk($sformatf("v%0d_pc_we", i), s.pc_we_n, vecs[i].pc_n);
            chk($sformatf("v%0d_pc_src", i), s.pc_src_v, vecs[i].psrc);
            chk($sformatf("v%0d_rf_we", i), s.rf_we_n, vecs[i].rf_n);
            if (vecs[i].rf_n > 0) begin
                chk($sformatf("v%0d_wb_sel", i), s.wb_sel_v, vecs[i].wsel);
                chk($sformatf("v%0d_ir2rf", i), s.ir_to_rf,
                    vecs[i].lat - 1);
            end
            chk($sformatf("v%0d_dreq", i), s.dreq_n, vecs[i].dreq);
            chk($sformatf("v%0d_dwe", i), s.dwe_n, vecs[i].dwe);
            chk($sformatf("v%0d_idle0", i), s.bad, 0);
        end

        // Fetch ready on the last allowed wait cycle wins over timeout
        run_gen(ADDI, 1'b0, TO - 1, 0, s);
        chk("ilimit_lat", s.lat, 4 + TO - 1);
        chk("ilimit_ireq", s.ireq_n, TO);
        chk("ilimit_bus_err", 32'(bus_err), 32'd0);
        chk("ilimit_rf_we", s.rf_we_n, 1);

        // Store with three wait states
        run_gen(SW, 1'b0, 0, 3, s);
        chk("sw_dreq", s.dreq_n, 4);
        chk("sw_dwe", s.dwe_n, 4);
        chk("sw_pc_we", s.pc_we_n, 1);
        chk("sw_pc_on_rdy", s.pc_on_drdy, 1);
        chk("sw_rf_we", s.rf_we_n, 0);
        chk("sw_imm", 32'(imm_op), 32'(IMM_S));
        chk("sw_lat", s.lat, 7);
        chk("sw_bus_err", 32'(bus_err), 32'd0);

        // Reset in the middle of a load's memory phase
        ir = LW;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        n = 0;
        while (!dmem_req && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ld_mem_reached", 32'(dmem_req), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_dreq_drop", 32'({dmem_req, rf_we, pc_we}), 32'd0);
        pulses = 3'd0;
        repeat (2) begin
            @(negedge clk);
            #1 pulses = pulses | {rf_we, pc_we, ir_we};
        end
        chk("rst_no_pulse", 32'(pulses), 32'd0);
        imem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_idle", 32'(imem_req), 32'd0);
`ifdef CTRL_PERF_EN
        chk("perf_cycle0", cycle_cnt, 32'd0);
        chk("perf_instret0", instret_cnt, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rel_fetch", 32'(imem_req), 32'd1);
        do_reset();

        // Illegal opcode traps and stays quiet
        run_gen(32'h0000007F, 1'b0, 0, 0, s);
        chk("ill_flag", 32'(illegal_instr), 32'd1);
        chk("ill_bus_err", 32'(bus_err), 32'd0);
        chk("ill_halted", 32'(halted), 32'd0);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (imem_req | dmem_req | ir_we | pc_we | rf_we) n++;
        end
        chk("ill_quiet", n, 0);
        chk("ill_sticky", 32'(illegal_instr), 32'd1);
        do_reset();
        chk("ill_cleared", 32'(illegal_instr), 32'd0);

        // ECALL halts
        run_gen(32'h00000073, 1'b0, 0, 0, s);
        chk("ecall_halted", 32'(halted), 32'd1);
        chk("ecall_illegal", 32'(illegal_instr), 32'd0);
        do_reset();

        // Instruction fetch never completes
        run_gen(ADDI, 1'b0, 99, 0, s);
        chk("ito_bus_err", 32'(bus_err), 32'd1);
        chk("ito_ireq", s.ireq_n, TO);
        chk("ito_ir_we", s.ir_we_n, 0);
        chk("ito_req_drop", 32'(imem_req), 32'd0);
        chk("ito_illegal", 32'(illegal_instr), 32'd0);
        do_reset();

        // Load data never arrives
        run_gen(LW, 1'b0, 0, 99, s);
        chk("dto_bus_err", 32'(bus_err), 32'd1);
        chk("dto_dreq", s.dreq_n, TO);
        chk("dto_rf_we", s.rf_we_n, 0);
        chk("dto_req_drop", 32'(dmem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
